// File: rtl/hog_scan_counter.sv
// Raster-scan (row, col) generator over a NUM_ROWS x NUM_COLS grid; first position 1 cycle after start,
// frame_done 1 cycle after the last consumed position; en=0 freezes the scan indefinitely.
module hog_scan_counter #(
  parameter int COL_W      = 6,
  parameter int ROW_W      = 8,
  parameter int NUM_COLS   = 53,
  parameter int NUM_ROWS   = 128,
  parameter int WIN_W      = 2,
  parameter int WIN_H      = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  output logic [ROW_W-1:0] cnt_row,
  output logic [COL_W-1:0] cnt_col,
  output logic             busy,
  output logic             col_last,
  output logic             row_last,
  output logic             win_valid,
  output logic             frame_done
);

  if (COL_W < 1 || COL_W > 30 || NUM_COLS < 1 || NUM_COLS > (1 << COL_W)) begin : g_bad_cols
    $error("hog_scan_counter: NUM_COLS out of range for COL_W");
  end
  if (ROW_W < 1 || ROW_W > 30 || NUM_ROWS < 1 || NUM_ROWS > (1 << ROW_W)) begin : g_bad_rows
    $error("hog_scan_counter: NUM_ROWS out of range for ROW_W");
  end
  if (WIN_W < 1 || WIN_W > NUM_COLS || WIN_H < 1 || WIN_H > NUM_ROWS) begin : g_bad_win
    $error("hog_scan_counter: window larger than grid");
  end
  if (CONTINUOUS != 0 && CONTINUOUS != 1) begin : g_bad_mode
    $error("hog_scan_counter: CONTINUOUS must be 0 or 1");
  end

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] WIN_COL  = COL_W'(WIN_W - 1);
  localparam logic [ROW_W-1:0] WIN_ROW  = ROW_W'(WIN_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_frame_done;

  logic w_busy;
  logic w_at_last_col;
  logic w_at_last_row;

  assign w_busy        = (r_state == S_RUN);
  assign w_at_last_col = (r_col == LAST_COL);
  assign w_at_last_row = (r_row == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (en) begin
            if (!w_at_last_col) begin
              r_col <= r_col + COL_W'(1);
            end else begin
              r_col <= '0;
              if (!w_at_last_row) begin
                r_row <= r_row + ROW_W'(1);
              end else begin
                // Last position consumed: wrap to (0,0) and flag the frame.
                r_row        <= '0;
                r_frame_done <= 1'b1;
                if (CONTINUOUS == 0) r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cnt_row    = r_row;
  assign cnt_col    = r_col;
  assign busy       = w_busy;
  assign col_last   = w_busy && w_at_last_col;
  assign row_last   = w_busy && w_at_last_row;
  assign win_valid  = w_busy && (r_row >= WIN_ROW) && (r_col >= WIN_COL);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hog_scan_counter.sv
// Scoreboard bench: expected outputs are queued with each driven step and checked #1 after the edge.
module tb_hog_scan_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] row;
    logic [5:0] col;
    logic       busy;
    logic       cl;
    logic       rl;
    logic       wv;
    logic       fd;
  } obs_t;

  // DUT A: 4x3 single-shot, counters exactly wide enough for the column range.
  logic [1:0] a_row;  logic [1:0] a_col;
  logic a_busy, a_cl, a_rl, a_wv, a_fd;
  hog_scan_counter #(.COL_W(2), .ROW_W(2), .NUM_COLS(4), .NUM_ROWS(3),
                     .WIN_W(2), .WIN_H(2), .CONTINUOUS(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .cnt_row(a_row), .cnt_col(a_col), .busy(a_busy), .col_last(a_cl),
    .row_last(a_rl), .win_valid(a_wv), .frame_done(a_fd));

  // DUT C: 4x3 continuous.
  logic [1:0] c_row;  logic [1:0] c_col;
  logic c_busy, c_cl, c_rl, c_wv, c_fd;
  hog_scan_counter #(.COL_W(2), .ROW_W(2), .NUM_COLS(4), .NUM_ROWS(3),
                     .WIN_W(2), .WIN_H(2), .CONTINUOUS(1)) u_c (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .cnt_row(c_row), .cnt_col(c_col), .busy(c_busy), .col_last(c_cl),
    .row_last(c_rl), .win_valid(c_wv), .frame_done(c_fd));

  // DUT B: default 53x128.
  logic [7:0] b_row;  logic [5:0] b_col;
  logic b_busy, b_cl, b_rl, b_wv, b_fd;
  hog_scan_counter u_b (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .cnt_row(b_row), .cnt_col(b_col), .busy(b_busy), .col_last(b_cl),
    .row_last(b_rl), .win_valid(b_wv), .frame_done(b_fd));

  // DUT D: single-column, two-row grid with 1-bit counters.
  logic [0:0] d_row;  logic [0:0] d_col;
  logic d_busy, d_cl, d_rl, d_wv, d_fd;
  hog_scan_counter #(.COL_W(1), .ROW_W(1), .NUM_COLS(1), .NUM_ROWS(2),
                     .WIN_W(1), .WIN_H(2), .CONTINUOUS(0)) u_d (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .cnt_row(d_row), .cnt_col(d_col), .busy(d_busy), .col_last(d_cl),
    .row_last(d_rl), .win_valid(d_wv), .frame_done(d_fd));

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t q_exp[$];

  function automatic obs_t idle_exp(input logic fd);
    obs_t e;
    e = '0;
    e.fd = fd;
    return e;
  endfunction

  function automatic obs_t pos_exp(input int r, input int c, input int nr, input int nc,
                                   input int wh, input int ww, input logic fd);
    obs_t e;
    e.row  = 8'(r);
    e.col  = 6'(c);
    e.busy = 1'b1;
    e.cl   = (c == nc - 1);
    e.rl   = (r == nr - 1);
    e.wv   = (r >= wh - 1) && (c >= ww - 1);
    e.fd   = fd;
    return e;
  endfunction

  function automatic obs_t sample(input int d);
    obs_t o;
    case (d)
      0:       o = '{8'(a_row), 6'(a_col), a_busy, a_cl, a_rl, a_wv, a_fd};
      1:       o = '{8'(c_row), 6'(c_col), c_busy, c_cl, c_rl, c_wv, c_fd};
      2:       o = '{b_row, b_col, b_busy, b_cl, b_rl, b_wv, b_fd};
      default: o = '{8'(d_row), 6'(d_col), d_busy, d_cl, d_rl, d_wv, d_fd};
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input int d, input logic rs, input logic st, input logic e,
                      input obs_t ex, input string tag);
    obs_t got, want;
    rst = rs; start = st; en = e;
    q_exp.push_back(ex);
    @(posedge clk);
    #1;
    got  = sample(d);
    want = q_exp.pop_front();
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got row=%0d col=%0d busy=%b cl=%b rl=%b wv=%b fd=%b, want row=%0d col=%0d busy=%b cl=%b rl=%b wv=%b fd=%b",
             tag, got.row, got.col, got.busy, got.cl, got.rl, got.wv, got.fd,
             want.row, want.col, want.busy, want.cl, want.rl, want.wv, want.fd);
    end
  endtask

  initial begin
    // Reset and idle with en high but no start.
    step(0, 1, 0, 1, idle_exp(0), "reset0");
    step(0, 1, 0, 1, idle_exp(0), "reset1");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, idle_exp(0), "idle_no_start");

    // Full single frame on 4x3.
    step(0, 0, 1, 1, pos_exp(0, 0, 3, 4, 2, 2, 0), "frame_first");
    for (int i = 1; i < 12; i++)
      step(0, 0, 0, 1, pos_exp(i / 4, i % 4, 3, 4, 2, 2, 0), "frame_pos");
    step(0, 0, 0, 1, idle_exp(1), "frame_done");
    step(0, 0, 0, 1, idle_exp(0), "frame_after");

    // Stall at (1,2) for 5 cycles, then resume.
    step(0, 0, 1, 0, pos_exp(0, 0, 3, 4, 2, 2, 0), "stall_first");
    for (int i = 1; i <= 6; i++)
      step(0, 0, 0, 1, pos_exp(i / 4, i % 4, 3, 4, 2, 2, 0), "stall_pre");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, pos_exp(1, 2, 3, 4, 2, 2, 0), "stall_hold");
    for (int i = 7; i < 12; i++)
      step(0, 0, 0, 1, pos_exp(i / 4, i % 4, 3, 4, 2, 2, 0), "stall_resume");
    step(0, 0, 0, 1, idle_exp(1), "stall_done");
    step(0, 0, 0, 1, idle_exp(0), "stall_after");

    // Start while running and while in DONE is ignored.
    step(0, 0, 1, 1, pos_exp(0, 0, 3, 4, 2, 2, 0), "ign_first");
    step(0, 0, 0, 1, pos_exp(0, 1, 3, 4, 2, 2, 0), "ign_pos");
    step(0, 0, 0, 1, pos_exp(0, 2, 3, 4, 2, 2, 0), "ign_pos");
    step(0, 0, 1, 1, pos_exp(0, 3, 3, 4, 2, 2, 0), "ign_start_run");
    for (int i = 4; i < 12; i++)
      step(0, 0, 0, 1, pos_exp(i / 4, i % 4, 3, 4, 2, 2, 0), "ign_pos");
    step(0, 0, 0, 1, idle_exp(1), "ign_done");
    step(0, 0, 1, 1, idle_exp(0), "ign_start_done");
    step(0, 0, 0, 1, idle_exp(0), "ign_no_queue");

    // Mid-frame reset at (1,1).
    step(0, 0, 1, 1, pos_exp(0, 0, 3, 4, 2, 2, 0), "abort_first");
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 1, pos_exp(i / 4, i % 4, 3, 4, 2, 2, 0), "abort_pos");
    step(0, 1, 0, 1, idle_exp(0), "abort_rst");
    step(0, 0, 0, 1, idle_exp(0), "abort_no_done");
    step(0, 0, 0, 1, idle_exp(0), "abort_idle");

    // Continuous mode: frame_done with (0,0) every 12 consumed positions.
    step(1, 1, 0, 0, idle_exp(0), "cont_reset");
    step(1, 0, 1, 1, pos_exp(0, 0, 3, 4, 2, 2, 0), "cont_first");
    for (int i = 1; i <= 30; i++)
      step(1, 0, 0, 1, pos_exp((i % 12) / 4, i % 4, 3, 4, 2, 2, (i % 12) == 0), "cont_pos");

    // Degenerate single-column grid: row advances every consumed cycle.
    step(3, 1, 0, 0, idle_exp(0), "deg_reset");
    step(3, 0, 1, 1, pos_exp(0, 0, 2, 1, 2, 1, 0), "deg_first");
    step(3, 0, 0, 1, pos_exp(1, 0, 2, 1, 2, 1, 0), "deg_row1");
    step(3, 0, 0, 1, idle_exp(1), "deg_done");
    step(3, 0, 0, 1, idle_exp(0), "deg_after");

    // Default 53x128 frame: 6784 consumed positions.
    step(2, 1, 0, 0, idle_exp(0), "def_reset");
    step(2, 0, 1, 1, pos_exp(0, 0, 128, 53, 2, 2, 0), "def_first");
    for (int i = 1; i < 6784; i++)
      step(2, 0, 0, 1, pos_exp(i / 53, i % 53, 128, 53, 2, 2, 0), "def_pos");
    step(2, 0, 0, 1, idle_exp(1), "def_done");
    step(2, 0, 0, 1, idle_exp(0), "def_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hog_scan_counter.md
Name: hog_scan_counter

Overview:
Parametrised raster-scan position generator for the HOG pipeline, successor to the fixed 53-column cell counter. It walks (row, col) over a NUM_ROWS x NUM_COLS grid under a start/enable handshake. It flags row/column ends and sliding-window validity, and pulses frame completion. It supports single-shot and continuous (back-to-back frame) modes.

Parameters:
COL_W, 6, width of cnt_col
ROW_W, 8, width of cnt_row
NUM_COLS, 53, columns per row; legal range 1..2^COL_W
NUM_ROWS, 128, rows per frame; legal range 1..2^ROW_W
WIN_W, 2, sliding-window width in columns; legal range 1..NUM_COLS
WIN_H, 2, sliding-window height in rows; legal range 1..NUM_ROWS
CONTINUOUS, 0, 0 = stop after one frame; 1 = restart automatically at frame end

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a frame; honoured only in IDLE
en  input  1  advance qualifier; current position consumed when busy && en
cnt_row  output  ROW_W  current row index, registered
cnt_col  output  COL_W  current column index, registered
busy  output  1  high in RUN
col_last  output  1  busy && cnt_col == NUM_COLS-1
row_last  output  1  busy && cnt_row == NUM_ROWS-1
win_valid  output  1  busy && cnt_row >= WIN_H-1 && cnt_col >= WIN_W-1
frame_done  output  1  one-cycle pulse, registered, after last position consumed

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, cnt_row=0, cnt_col=0, frame_done=0; busy/col_last/row_last/win_valid therefore 0. Reset overrides all inputs, including mid-frame; no frame_done is issued for an aborted frame.
- States: IDLE, RUN, DONE.
- IDLE: counters held at 0. start=1 -> RUN next cycle, with (0,0) presented in the first RUN cycle. en is ignored.
- RUN, en=0: everything holds; there is no timeout.
- RUN, en=1, not last column: cnt_col+1.
- RUN, en=1, cnt_col==NUM_COLS-1, not last row: cnt_col=0, cnt_row+1.
- RUN, en=1, last position (NUM_ROWS-1, NUM_COLS-1), CONTINUOUS=0: counters -> 0, state -> DONE.
- RUN, en=1, last position, CONTINUOUS=1: counters -> 0, state stays RUN, frame_done=1 next cycle. The next frame's (0,0) is presented in that same cycle.
- DONE: frame_done=1 for exactly one cycle, then IDLE unconditionally. start in DONE is ignored (earliest restart is start in the following IDLE cycle).
- start in RUN or DONE is ignored, with no queuing.
- Degenerate grids: NUM_COLS=1 increments the row every consumed cycle. A 1x1 grid finishes on the first en cycle.
- Arithmetic: counters compare against NUM_COLS-1 / NUM_ROWS-1 only and never exceed them. No modular overflow of the COL_W/ROW_W fields occurs for legal parameters. Illegal parameters are rejected at elaboration.
- Flags are combinational from state and counter registers (zero added latency), aligned with the cnt_row/cnt_col they describe.
- Latency: start -> first position 1 cycle. Last consumed position -> frame_done 1 cycle. A full frame with en tied high is NUM_ROWS*NUM_COLS RUN cycles.

Test Plan:
- Reset/idle (NUM_COLS=4, NUM_ROWS=3): assert rst 2 cycles, en=1, no start -> cnt_row=0, cnt_col=0, busy=0, frame_done never asserted.
- Full single frame (4x3, WIN 2x2, en=1): start pulse -> 12 RUN cycles sequence (0,0),(0,1)...(2,3). col_last high at cols 3; row_last high for the 4 row-2 cycles. win_valid high at (1,1..3),(2,1..3), i.e. 6 cycles. frame_done high 1 cycle immediately after (2,3), then busy=0.
- Stall: in RUN hold en=0 for 5 cycles at (1,2) -> outputs frozen at (1,2), flags unchanged. Resume -> (1,3) next.
- Continuous (CONTINUOUS=1, 4x3): start once, en=1 for 30 cycles -> frame_done pulses at cycles 13 and 25 after start. busy never drops. (0,0) coincides with each pulse.
- Ignored start / mid-frame reset: start pulses at (0,2) and in DONE -> no effect. Then rst at (1,1) -> next cycle IDLE, (0,0), no frame_done.
- Default parameters (53x128): run a full frame -> col wraps 52->0 with row increment; frame_done after exactly 6784 en cycles.
